// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if: operand stream, MAC drive and result bundle.
// Ports: in_* operand handshake, mac_* MAC drive/feedback, res_* result handshake.
// Modports: master = source/MAC/result-sink side, slave = sequencer.
interface mac_sequencer_if #(
    parameter int OP_W  = 2,
    parameter int ACC_W = 4,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_a;
    logic [OP_W-1:0]  in_b;
    logic             in_last;
    logic [OP_W-1:0]  mac_a;
    logic [OP_W-1:0]  mac_b;
    logic             mac_en;
    logic             mac_clr;
    logic [ACC_W-1:0] mac_acc;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic [CNT_W-1:0] res_count;

    modport master (
        output in_valid, in_a, in_b, in_last, mac_acc, res_ready,
        input  in_ready, mac_a, mac_b, mac_en, mac_clr,
        input  res_valid, res_data, res_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, mac_acc, res_ready,
        output in_ready, mac_a, mac_b, mac_en, mac_clr,
        output res_valid, res_data, res_count
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer: buffers operand pairs, frames each vector with a MAC clear,
// issues one pair per cycle and returns the accumulated dot product.
// Ports: clk, rst_n (async active-low), bus (mac_sequencer_if.slave).
module mac_sequencer #(
    parameter int OP_W  = 2,
    parameter int ACC_W = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_sequencer_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = 2 * OP_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        RESULT
    } state_t;

    state_t state;
    state_t state_nx;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   used;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             head_last;
    logic [OP_W-1:0]  head_a;
    logic [OP_W-1:0]  head_b;

    logic [OP_W-1:0]  mac_a_q;
    logic [OP_W-1:0]  mac_b_q;
    logic             mac_en_q;
    logic             mac_clr_q;
    logic [CNT_W-1:0] cnt;
    logic             res_valid_q;
    logic [ACC_W-1:0] res_data_q;
    logic [CNT_W-1:0] res_count_q;

    assign full  = (used == (PTR_W+1)'(DEPTH));
    assign empty = (used == '0);

    // No bypass: a full FIFO refuses even when popping this cycle.
    assign bus.in_ready = rst_n && !full;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (state == ISSUE) && !empty;

    assign {head_last, head_a, head_b} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_a, bus.in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   used <= used + (PTR_W+1)'(1);
                2'b01:   used <= used - (PTR_W+1)'(1);
                default: used <= used;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!empty) state_nx = CLEAR;
            CLEAR:   state_nx = ISSUE;
            ISSUE:   if (pop && head_last) state_nx = WAIT;
            WAIT:    state_nx = RESULT;
            RESULT:  if (res_valid_q && bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            cnt         <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
        end else begin
            state     <= state_nx;
            // Registered so the clear is visible exactly while in CLEAR.
            mac_clr_q <= (state_nx == CLEAR);
            mac_en_q  <= pop;
            mac_a_q   <= pop ? head_a : '0;
            mac_b_q   <= pop ? head_b : '0;

            if (state == CLEAR) begin
                cnt <= '0;
            end else if (pop && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end

            // First RESULT cycle: mac_acc now includes the last product.
            if (state == RESULT) begin
                if (!res_valid_q) begin
                    res_valid_q <= 1'b1;
                    res_data_q  <= bus.mac_acc;
                    res_count_q <= cnt;
                end else if (bus.res_ready) begin
                    res_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_count = res_count_q;
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Issue-side companion to the MAC datapath: accepts a stream of operand pairs and drives them into the MAC, one pair per cycle.
- Frames each vector with an accumulator clear, then returns the final accumulated dot product on a valid/ready result port.
- Sits between the operand source and the MAC. It buffers operands in a small FIFO, so the source never has to track accumulator timing.

Parameters:
- OP_W, 2, operand width of a and b
- ACC_W, 4, MAC accumulator width (result width)
- DEPTH, 4, operand FIFO entries (power of two, >=2)
- CNT_W, 4, width of the issued-pair counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  FIFO can accept a pair
- in_a  input  OP_W  operand a
- in_b  input  OP_W  operand b
- in_last  input  1  marks the final pair of a vector
- mac_a  output  OP_W  operand a to MAC
- mac_b  output  OP_W  operand b to MAC
- mac_en  output  1  MAC accumulates a*b on this edge
- mac_clr  output  1  MAC accumulator clear (takes priority over mac_en)
- mac_acc  input  ACC_W  MAC accumulator value (registered in MAC)
- res_valid  output  1  result available
- res_ready  input  1  result consumer accepts
- res_data  output  ACC_W  captured dot product
- res_count  output  CNT_W  pairs issued in the vector, saturating

Behaviour:
- Reset values:
  - in_ready=0 while rst_n low, 1 after reset (FIFO empty).
  - mac_a=0, mac_b=0, mac_en=0, mac_clr=0.
  - res_valid=0, res_data=0, res_count=0.
  - FIFO empty, FSM in IDLE, counter 0.
- FIFO:
  - Push when in_valid && in_ready; stores {in_last, in_a, in_b}.
  - in_ready = !full. No bypass: when full, a push is refused even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full: occupancy unchanged.
- FSM states:
  - IDLE: wait for FIFO non-empty, then go to CLEAR.
  - CLEAR: mac_clr=1 for exactly one cycle; counter cleared; go to ISSUE.
  - ISSUE:
    - If FIFO non-empty: pop one entry, drive mac_a/mac_b with it, mac_en=1, increment counter (saturates at 2^CNT_W-1).
    - If popped entry has last=1, go to WAIT.
    - If FIFO empty: bubble with mac_en=0, mac_a=mac_b=0; stay in ISSUE.
  - WAIT: one cycle so the MAC register absorbs the last product; mac_en=0; go to RESULT.
  - RESULT:
    - On entry, capture res_data=mac_acc and res_count=counter; res_valid=1.
    - Hold res_data and res_count stable while res_valid && !res_ready.
    - On res_valid && res_ready: res_valid=0, go to IDLE.
- Outputs and timing:
  - mac_a, mac_b, mac_en, mac_clr are registered outputs.
  - mac_a/mac_b are forced to 0 whenever mac_en=0.
- Latency: the last pair popped in cycle T gives res_valid high in cycle T+3 (T+1: MAC accumulates, T+2: WAIT, T+3: capture).
- Arithmetic:
  - MAC sum wraps modulo 2^ACC_W. The sequencer neither extends nor checks it.
  - The counter saturates and does not wrap.
- Pipelining: the FIFO keeps accepting the next vector while a vector is in WAIT/RESULT. The next CLEAR occurs only after the current result handshake completes.
- Vector of one pair (first entry has last=1): valid; res_data = a*b.
- Reset mid-operation:
  - Immediate return to all reset values; FIFO contents discarded.
  - Any in-flight vector is lost with no result.
  - The MAC accumulator is not cleared by rst_n. The next vector's CLEAR guarantees correctness.

Test Plan:
- Single vector (1,2),(3,3),(2,1,last), res_ready=1 -> mac_clr pulse; three mac_en cycles; res_data=13, res_count=3; res_valid 3 cycles after the last pop.
- Wrap-around with ACC_W=4: (3,3),(3,3,last) -> res_data=2 (18 mod 16), res_count=2.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data/res_count stable. Next vector pushed meanwhile fills the FIFO: in_ready=0 after 4 pushes, no mac_clr until the handshake.
- Source starvation: pairs (1,1),(gap 3 cycles),(2,2,last) -> bubble cycles show mac_en=0, mac_a=mac_b=0; res_data=5.
- Full FIFO with simultaneous pop: FIFO full, in_valid=1 during an ISSUE pop -> push refused that cycle, accepted the next; no entry lost or duplicated.
- Reset mid-ISSUE: assert rst_n low after 2 of 4 pairs issued -> all outputs 0 immediately. A new vector (2,3,last) then gives res_data=6, unaffected by the stale accumulator.
